pipelined_csel_adder: RTL

- Parametrised, pipelined carry-select adder/subtractor.
- Operands are split into BLOCK-bit segments. Each pipeline stage resolves one segment: both carry-in hypotheses are computed, then the real carry from the previous stage selects between them.
- Valid/ready handshake on both sides, full back-pressure, one result per cycle sustained.
- Sits on the datapath wherever wide add/sub must close timing at high clock rates.

---
 rtl/pipelined_csel_adder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor.
// The operands are cut into BLOCK-bit segments and each pipeline stage
// resolves one segment. For its segment a stage forms both carry-in
// hypotheses (carry-in 0 and carry-in 1) with ripple adders. The real
// carry, registered by the previous stage, then picks one of them.
// Upstream and downstream use a valid/ready handshake. Bubbles collapse,
// and the block sustains one beat per cycle.
`timescale 1ns/1ps

module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // The guard on BLOCK keeps the division legal for an illegal BLOCK,
  // so that the check below reports the real problem.
  localparam int NSTG = (BLOCK < 1) ? 1 : (WIDTH / BLOCK);

  if ((BLOCK < 1) ? 1'b1 : ((WIDTH % BLOCK) != 0)) begin : g_param_check
    $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Ripple adder for one segment.
  // Returns {carry out, carry into segment MSB, segment sum}.
  function automatic logic [BLOCK+1:0] seg_add(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK-1:0] s;
    logic             c;
    logic             cm;
    c  = ci;
    cm = ci;
    s  = {BLOCK{1'b0}};
    for (int i = 0; i < BLOCK; i++) begin
      cm   = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, cm, s};
  endfunction

  // Resolve segment k of a beat.
  // Returns {signed overflow, carry out, partial sum}. The partial sum is
  // 'part' with segment k filled in. The overflow bit only means anything
  // for the most significant segment.
  function automatic logic [WIDTH+1:0] stage_eval(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [WIDTH-1:0] part,
    input logic             c_in,
    input int               k
  );
    logic [BLOCK+1:0] hyp0;
    logic [BLOCK+1:0] hyp1;
    logic [BLOCK+1:0] pick;
    logic [WIDTH-1:0] res;
    hyp0 = seg_add(op_a[k*BLOCK +: BLOCK], op_b[k*BLOCK +: BLOCK], 1'b0);
    hyp1 = seg_add(op_a[k*BLOCK +: BLOCK], op_b[k*BLOCK +: BLOCK], 1'b1);
    if (c_in) begin
      pick = hyp1;
    end else begin
      pick = hyp0;
    end
    res = part;
    res[k*BLOCK +: BLOCK] = pick[BLOCK-1:0];
    return {pick[BLOCK+1] ^ pick[BLOCK], pick[BLOCK+1], res};
  endfunction

  // Stage registers. Index k holds the state that stage k has produced.
  logic [WIDTH-1:0] opa_r [NSTG];
  logic [WIDTH-1:0] opb_r [NSTG];
  logic [WIDTH-1:0] sum_r [NSTG];
  logic [NSTG-1:0]  cry_r;
  logic [NSTG-1:0]  vld_r;
  logic             ovf_r;

  // Combinational stage inputs and results.
  logic [WIDTH-1:0] prep_b_s;
  logic             prep_c_s;
  logic [WIDTH-1:0] src_a_s [NSTG];
  logic [WIDTH-1:0] src_b_s [NSTG];
  logic [WIDTH-1:0] src_p_s [NSTG];
  logic [NSTG-1:0]  src_c_s;
  logic [NSTG-1:0]  src_vld_s;
  logic [WIDTH+1:0] res_s [NSTG];
  logic [NSTG-1:0]  ld_s;

  // Operand preparation: subtract is A + ~B + 1, so the carry-in is forced to 1.
  always_comb begin
    if (sub) begin
      prep_b_s = ~b;
      prep_c_s = 1'b1;
    end else begin
      prep_b_s = b;
      prep_c_s = cin;
    end
  end

  // Route into each stage the data it works on. Stage 0 takes the prepared
  // operands. Every later stage takes the registers of the stage below it.
  always_comb begin
    src_a_s[0]   = a;
    src_b_s[0]   = prep_b_s;
    src_p_s[0]   = {WIDTH{1'b0}};
    src_c_s      = {NSTG{1'b0}};
    src_vld_s    = {NSTG{1'b0}};
    src_c_s[0]   = prep_c_s;
    src_vld_s[0] = in_valid;
    for (int k = 1; k < NSTG; k++) begin
      src_a_s[k]   = opa_r[k-1];
      src_b_s[k]   = opb_r[k-1];
      src_p_s[k]   = sum_r[k-1];
      src_c_s[k]   = cry_r[k-1];
      src_vld_s[k] = vld_r[k-1];
    end
  end

  // Carry-select evaluation of each stage's own segment.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      res_s[k] = stage_eval(src_a_s[k], src_b_s[k], src_p_s[k], src_c_s[k], k);
    end
  end

  // Load enables.
  // A stage may take new content when it is empty or when its successor
  // is taking its current content. The last stage depends on out_ready.
  always_comb begin
    ld_s = {NSTG{1'b0}};
    ld_s[NSTG-1] = !vld_r[NSTG-1] || out_ready;
    for (int k = NSTG - 2; k >= 0; k--) begin
      ld_s[k] = !vld_r[k] || ld_s[k+1];
    end
  end

  // Pipeline registers.
  // Each stage loads when enabled and freezes when stalled. Data registers
  // only change when a valid beat enters, so idle stages do not toggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= {NSTG{1'b0}};
      cry_r <= {NSTG{1'b0}};
      ovf_r <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        opa_r[k] <= {WIDTH{1'b0}};
        opb_r[k] <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (ld_s[k]) begin
          vld_r[k] <= src_vld_s[k];
          if (src_vld_s[k]) begin
            opa_r[k] <= src_a_s[k];
            opb_r[k] <= src_b_s[k];
            sum_r[k] <= res_s[k][WIDTH-1:0];
            cry_r[k] <= res_s[k][WIDTH];
          end
        end
      end
      if (ld_s[NSTG-1] && src_vld_s[NSTG-1]) begin
        ovf_r <= res_s[NSTG-1][WIDTH+1];
      end
    end
  end

  // Outputs come straight from the last stage's registers.
  assign in_ready  = ld_s[0];
  assign out_valid = vld_r[NSTG-1];
  assign sum       = sum_r[NSTG-1];
  assign cout      = cry_r[NSTG-1];
  assign ovf       = ovf_r;

endmodule
